// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the registered ALU.
//   alu_seq_func_e  - 4-bit operation select (14 and 15 are unassigned/illegal)
//   alu_seq_state_e - sequencer states (IDLE, MUL_BUSY)
package alu_seq_pkg;

  localparam int ALU_SEQ_FUNC_W = 4;

  typedef enum logic [ALU_SEQ_FUNC_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_INV = 4'd5,
    ALU_ADC = 4'd6,
    ALU_SBC = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_ASR = 4'd10,
    ALU_ROL = 4'd11,
    ALU_ROR = 4'd12,
    ALU_MUL = 4'd13
  } alu_seq_func_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request handshake, operands and registered status of alu_seq.
//   master: requester (drives in_valid, alu_func, operand_a, operand_b)
//   slave : alu_seq   (drives in_ready, out_valid and the flag outputs)
// The tristate result bus is a plain port of alu_seq, not part of this bundle.
interface alu_seq_if #(parameter int DATA_W = 8);
  import alu_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  alu_seq_func_e     alu_func;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              out_valid;
  logic              zero_flag;
  logic              positive_flag;
  logic              carry_flag;
  logic              signed_overflow;
  logic              illegal_op;

  modport master (
    output in_valid, alu_func, operand_a, operand_b,
    input  in_ready, out_valid, zero_flag, positive_flag, carry_flag,
           signed_overflow, illegal_op
  );

  modport slave (
    input  in_valid, alu_func, operand_a, operand_b,
    output in_ready, out_valid, zero_flag, positive_flag, carry_flag,
           signed_overflow, illegal_op
  );

endinterface

// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: iterative unsigned shift-add multiplier, one partial
// product per clock. Built only when ALU_SEQ_MUL_EN is defined.
//   clk, rst     - clock, synchronous active-high reset (aborts a multiply)
//   start        - load operands, counter := DATA_W
//   multiplicand, multiplier - operands, sampled on start
//   busy         - iterations remain
//   done         - the step taken at the coming edge is the last one
//   product      - full 2*DATA_W product, valid while done is high
module alu_seq_multiplier #(parameter int DATA_W = 8) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;

  assign busy = (cnt != '0);
  assign done = busy && (cnt == CNT_W'(1));

  // Accumulator value after this cycle's step; on the last step it is the
  // finished product, so the top can register it on the same edge.
  assign product = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(DATA_W);
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, multiplicand};
      mplier <= multiplier;
    end else if (busy) begin
      cnt    <= cnt - CNT_W'(1);
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/tristate_driver.sv
// tristate_driver: drives bus with data while en is high, releases it otherwise.
//   en   - drive enable
//   data - value to drive
//   bus  - shared tristate net
module tristate_driver #(parameter int WIDTH = 8) (
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output tri   [WIDTH-1:0] bus
);

  assign bus = en ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready request, registered result/flags
// and a tristate result bus.
//   clk, rst      - clock, synchronous active-high reset
//   bus (slave)   - in_valid/in_ready, alu_func, operands, out_valid, flags
//   output_enable - drive alu_result from the result register when high
//   alu_result    - tristate result bus
// Build option ALU_SEQ_MUL_EN: adds the multi-cycle MUL (func 13) and the
// MUL_BUSY state; without it func 13 is illegal and in_ready is 1 outside reset.
//
// state       | meaning
// ST_IDLE     | ready; single-cycle ops complete on their accept edge
// ST_MUL_BUSY | shift-add multiply in progress; requests are ignored
module alu_seq
  import alu_seq_pkg::*;
#(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rst,
  alu_seq_if.slave          bus,
  input  logic              output_enable,
  output tri   [DATA_W-1:0] alu_result
);

  localparam int SHAMT_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   result_q;
  logic                zero_q, pos_q, carry_q, ovf_q, ill_q, out_valid_q;
  logic                in_ready, accept, mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  logic [DATA_W-1:0]   a, b, b_eff;
  logic [SHAMT_W-1:0]  shamt, rot_amt;
  logic                sub_op, cin, add_v;
  logic [DATA_W:0]     sum, shl_ext, shr_ext;
  logic signed [DATA_W:0] asr_ext;
  logic [2*DATA_W-1:0] rol_ext, ror_ext;

  logic                wr_en, wr_c, wr_v, wr_ill;
  logic [DATA_W-1:0]   wr_res;

  assign a      = bus.operand_a;
  assign b      = bus.operand_b;
  assign shamt  = b[SHAMT_W-1:0];
  assign accept = bus.in_valid && in_ready;

  // Subtraction as a + ~b + cin: SUB forces cin=1, ADC/SBC chain the carry,
  // so carry out is not-borrow and one overflow rule covers all four ops.
  assign sub_op = (bus.alu_func == ALU_SUB) || (bus.alu_func == ALU_SBC);
  assign b_eff  = sub_op ? ~b : b;
  assign cin    = (bus.alu_func == ALU_ADD) ? 1'b0 :
                  (bus.alu_func == ALU_SUB) ? 1'b1 : carry_q;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + (DATA_W+1)'(cin);
  assign add_v  = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

  // One extra bit beside each shift catches the last bit shifted out.
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;
  assign asr_ext = $signed({a, 1'b0}) >>> shamt;
  assign rot_amt = SHAMT_W'(shamt % DATA_W);
  assign rol_ext = {a, a} << rot_amt;
  assign ror_ext = {a, a} >> rot_amt;

`ifdef ALU_SEQ_MUL_EN
  alu_seq_state_e state, next_state;
  logic           mul_busy;

  assign mul_start = accept && (bus.alu_func == ALU_MUL);
  assign in_ready  = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (mul_start) next_state = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done || !mul_busy) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  alu_seq_multiplier #(.DATA_W(DATA_W)) u_mult (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .multiplicand (a),
    .multiplier   (b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );
`else
  assign in_ready    = ~rst;
  assign mul_start   = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_comb begin
    wr_en  = 1'b0;
    wr_res = '0;
    wr_c   = carry_q;
    wr_v   = ovf_q;
    wr_ill = 1'b0;
    if (mul_done) begin
      wr_en  = 1'b1;
      wr_res = mul_product[DATA_W-1:0];
      wr_c   = |mul_product[2*DATA_W-1:DATA_W];
    end else if (accept && !mul_start) begin
      wr_en = 1'b1;
      case (bus.alu_func)
        ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC: begin
          wr_res = sum[DATA_W-1:0];
          wr_c   = sum[DATA_W];
          wr_v   = add_v;
        end
        ALU_AND: wr_res = a & b;
        ALU_OR:  wr_res = a | b;
        ALU_XOR: wr_res = a ^ b;
        ALU_INV: wr_res = ~a;
        ALU_SHL: begin
          wr_res = shl_ext[DATA_W-1:0];
          if (shamt != '0) wr_c = shl_ext[DATA_W];
        end
        ALU_SHR: begin
          wr_res = shr_ext[DATA_W:1];
          if (shamt != '0) wr_c = shr_ext[0];
        end
        ALU_ASR: begin
          wr_res = asr_ext[DATA_W:1];
          if (shamt != '0) wr_c = asr_ext[0];
        end
        ALU_ROL: begin
          wr_res = rol_ext[2*DATA_W-1:DATA_W];
          if (shamt != '0) wr_c = rol_ext[DATA_W];
        end
        ALU_ROR: begin
          wr_res = ror_ext[DATA_W-1:0];
          if (shamt != '0) wr_c = ror_ext[DATA_W-1];
        end
        default: wr_ill = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      pos_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= wr_en;
      if (wr_en) begin
        result_q <= wr_res;
        zero_q   <= (wr_res == '0);
        pos_q    <= ~wr_res[DATA_W-1];
        carry_q  <= wr_c;
        ovf_q    <= wr_v;
        ill_q    <= wr_ill;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.zero_flag       = zero_q;
  assign bus.positive_flag   = pos_q;
  assign bus.carry_flag      = carry_q;
  assign bus.signed_overflow = ovf_q;
  assign bus.illegal_op      = ill_q;

  tristate_driver #(.WIDTH(DATA_W)) u_result_drv (
    .en   (output_enable),
    .data (result_q),
    .bus  (alu_result)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: testbench for alu_seq at DATA_W = 8.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         oe;
  logic         drv_en;
  logic [W-1:0] drv_val;
  tri   [W-1:0] alu_result;

  int checks = 0;
  int errors = 0;

  // reference state
  int m_res, m_z, m_p, m_c, m_v, m_ill;

  alu_seq_if #(.DATA_W(W)) bus ();

  alu_seq #(.DATA_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .output_enable (oe),
    .alu_result    (alu_result)
  );

  // second driver on the result net; only active while the DUT should be released
  assign alu_result = drv_en ? drv_val : {W{1'bz}};

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic void model_reset();
    m_res = 0; m_z = 0; m_p = 0; m_c = 0; m_v = 0; m_ill = 0;
  endfunction

  function automatic void model_apply(input int f, input int a, input int b);
    int full, sr, s;
    bit ill;
    s   = b % W;
    ill = 1'b0;
    case (f)
      0:  begin full = a + b;              sr = sx(a) + sx(b);
                m_res = full & 255; m_c = int'(full > 255); m_v = int'(sr > 127 || sr < -128); end
      1:  begin full = a - b;              sr = sx(a) - sx(b);
                m_res = full & 255; m_c = int'(full >= 0);  m_v = int'(sr > 127 || sr < -128); end
      6:  begin full = a + b + m_c;        sr = sx(a) + sx(b) + m_c;
                m_res = full & 255; m_c = int'(full > 255); m_v = int'(sr > 127 || sr < -128); end
      7:  begin full = a - b - (1 - m_c);  sr = sx(a) - sx(b) - (1 - m_c);
                m_res = full & 255; m_c = int'(full >= 0);  m_v = int'(sr > 127 || sr < -128); end
      2:  m_res = a & b;
      3:  m_res = a | b;
      4:  m_res = a ^ b;
      5:  m_res = (~a) & 255;
      8:  begin m_res = (a << s) & 255; if (s != 0) m_c = (a >> (W - s)) & 1; end
      9:  begin m_res = a >> s;         if (s != 0) m_c = (a >> (s - 1)) & 1; end
      10: begin m_res = (sx(a) >>> s) & 255; if (s != 0) m_c = (a >> (s - 1)) & 1; end
      11: begin
            m_res = (s == 0) ? a : (((a << s) | (a >> (W - s))) & 255);
            if (s != 0) m_c = m_res & 1;
          end
      12: begin
            m_res = (s == 0) ? a : (((a >> s) | (a << (W - s))) & 255);
            if (s != 0) m_c = (m_res >> 7) & 1;
          end
      13: begin
            if (MUL_EN) begin full = a * b; m_res = full & 255; m_c = int'(full > 255); end
            else ill = 1'b1;
          end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      m_res = 0; m_z = 1; m_p = 1; m_ill = 1;
    end else begin
      m_z = int'(m_res == 0); m_p = int'(m_res < 128); m_ill = 0;
    end
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_res"}, alu_result, m_res);
    check_eq({tag, "_z"}, bus.zero_flag, m_z);
    check_eq({tag, "_p"}, bus.positive_flag, m_p);
    check_eq({tag, "_c"}, bus.carry_flag, m_c);
    check_eq({tag, "_v"}, bus.signed_overflow, m_v);
    check_eq({tag, "_ill"}, bus.illegal_op, m_ill);
  endtask

  // Called and returns at a negedge. With hold=1 in_valid stays high after the
  // first accept carrying (f2,a2,b2), which is taken as soon as ready returns.
  task automatic run_op(input string tag, input int f, input int a, input int b,
                        input bit hold, input int f2, input int a2, input int b2);
    int n, lat, low;
    bit is_mul;
    is_mul = MUL_EN && (f == 13);
    n = 0;
    while (!bus.in_ready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) check_eq({tag, "_ready_timeout"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.alu_func  = alu_seq_func_e'(4'(f));
    bus.operand_a = 8'(a);
    bus.operand_b = 8'(b);
    @(posedge clk);
    #1;
    model_apply(f, a, b);
    if (hold) begin
      bus.alu_func  = alu_seq_func_e'(4'(f2));
      bus.operand_a = 8'(a2);
      bus.operand_b = 8'(b2);
    end else begin
      bus.in_valid  = 1'b0;
      bus.alu_func  = alu_seq_func_e'(4'($urandom_range(0, 15)));
      bus.operand_a = 8'($urandom);
      bus.operand_b = 8'($urandom);
    end
    lat = 0;
    low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && !bus.in_ready) low++;
    end while (!bus.out_valid && lat < 64);
    check_eq({tag, "_lat"}, lat, is_mul ? W + 1 : 1);
    check_eq({tag, "_busy"}, low, is_mul ? W : 0);
    check_state(tag);
    if (hold) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      model_apply(f2, a2, b2);
      @(negedge clk);
      check_eq({tag, "_ov2"}, bus.out_valid, 1);
      check_state({tag, "_2"});
    end
    @(negedge clk);
    check_eq({tag, "_pulse"}, bus.out_valid, 0);
  endtask

  initial begin
    int ov_seen, f, f2;
    rst = 1'b1; oe = 1'b1; drv_en = 1'b0; drv_val = '0;
    bus.in_valid = 1'b0; bus.alu_func = ALU_ADD; bus.operand_a = '0; bus.operand_b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", bus.in_ready, 1);
    check_eq("rst_ov", bus.out_valid, 0);
    check_state("rst");

    run_op("add_ff_01", 0, 'hFF, 'h01, 0, 0, 0, 0);
    run_op("adc_0_0_a", 6, 'h00, 'h00, 0, 0, 0, 0);
    run_op("adc_0_0_b", 6, 'h00, 'h00, 0, 0, 0, 0);
    run_op("sub_80_01", 1, 'h80, 'h01, 0, 0, 0, 0);
    run_op("sbc_0_0",   7, 'h00, 'h00, 0, 0, 0, 0);
    run_op("shl_81_1",  8, 'h81, 'h01, 0, 0, 0, 0);
    run_op("asr_80_3", 10, 'h80, 'h03, 0, 0, 0, 0);
    run_op("ror_01_1", 12, 'h01, 'h01, 0, 0, 0, 0);
    run_op("shr_by_0",  9, 'h55, 'h00, 0, 0, 0, 0);
    run_op("rol_c3_4", 11, 'hC3, 'h04, 0, 0, 0, 0);
    run_op("mul_hold", 13, 'h10, 'h10, 1, 2, 'hA5, 'h0F);
    run_op("add_7f_01", 0, 'h7F, 'h01, 0, 0, 0, 0);
    run_op("illegal14", 14, 'h12, 'h34, 0, 0, 0, 0);
    run_op("and_f0_3c", 2, 'hF0, 'h3C, 0, 0, 0, 0);
    run_op("illegal15", 15, 'hFF, 'hFF, 1, 3, 'h0F, 'h30);

    oe = 1'b0; drv_en = 1'b1; drv_val = 8'hA5;
    #1 check_eq("oe_off_a5", alu_result, 8'hA5);
    drv_val = 8'h3C;
    #1 check_eq("oe_off_3c", alu_result, 8'h3C);
    drv_en = 1'b0; oe = 1'b1;
    #1 check_eq("oe_on", alu_result, m_res);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      f  = $urandom_range(0, 15);
      f2 = $urandom_range(0, 12);
      run_op("rand", f, $urandom_range(0, 255), $urandom_range(0, 255),
             ($urandom_range(0, 3) == 0), f2, $urandom_range(0, 255), $urandom_range(0, 255));
    end

    run_op("add_ff_ff", 0, 'hFF, 'hFF, 0, 0, 0, 0);
    bus.in_valid = 1'b1; bus.alu_func = ALU_MUL; bus.operand_a = 8'h33; bus.operand_b = 8'h07;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("mul_abort_ready", bus.in_ready, int'(!MUL_EN));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("mul_abort_ov", bus.out_valid, 0);
    check_eq("mul_abort_ready2", bus.in_ready, 1);
    check_state("mul_abort");
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check_eq("mul_abort_late_ov", ov_seen, 0);
    check_state("mul_abort_late");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
